// File: rtl/l2_bus_pkg.sv
// Shared types and ASCII opcode decode for the L2 bus request decoder.
package l2_bus_pkg;

  // Numbering matches the trace command numbering.
  typedef enum logic [2:0] {
    OP_DR = 3'd0,
    OP_DW = 3'd1,
    OP_IR = 3'd2,
    OP_SI = 3'd3,
    OP_SR = 3'd4,
    OP_SW = 3'd5,
    OP_SM = 3'd6
  } op_e;

  localparam logic [15:0] AsciiDr = 16'h4452;
  localparam logic [15:0] AsciiDw = 16'h4457;
  localparam logic [15:0] AsciiIr = 16'h4952;
  localparam logic [7:0]  AsciiI  = 8'h49;
  localparam logic [7:0]  AsciiR  = 8'h52;
  localparam logic [7:0]  AsciiW  = 8'h57;
  localparam logic [7:0]  AsciiM  = 8'h4D;

  typedef struct packed {
    logic legal;
    op_e  op;
  } dec_t;

  function automatic dec_t decode_l1(input logic [15:0] ascii);
    dec_t d;
    d.legal = 1'b1;
    d.op    = OP_DR;
    case (ascii)
      AsciiDr: d.op = OP_DR;
      AsciiDw: d.op = OP_DW;
      AsciiIr: d.op = OP_IR;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic dec_t decode_snoop(input logic [7:0] ascii);
    dec_t d;
    d.legal = 1'b1;
    d.op    = OP_SI;
    case (ascii)
      AsciiI:  d.op = OP_SI;
      AsciiR:  d.op = OP_SR;
      AsciiW:  d.op = OP_SW;
      AsciiM:  d.op = OP_SM;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// Synchronous FIFO; pushes while full and pops while empty are ignored.
module l2_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Fullness is taken from the pre-edge count, so a same-edge pop never frees a slot.
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage write; contents need no reset since the count guards reads.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/l2_bus_request_decoder.sv
// Decodes L1 and snoop ASCII ops, buffers each side, and presents one request at
// a time to the L2 controller with snoop priority and an L1 anti-starvation guard.
module l2_bus_request_decoder
  import l2_bus_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned L1_DEPTH        = 4,
  parameter int unsigned SNOOP_DEPTH     = 4,
  parameter int unsigned MAX_SNOOP_BURST = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              l1_valid,
  input  logic [15:0]       l1_op,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic              snoop_valid,
  input  logic [7:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [2:0]        req_op,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_is_snoop,
  output logic              l1_overflow,
  output logic              snoop_overflow,
  output logic              illegal_op,
  output logic [15:0]       illegal_count
);

  localparam int unsigned EntryW = ADDR_W + 3;
  localparam int unsigned BurstW = (MAX_SNOOP_BURST > 0) ? $clog2(MAX_SNOOP_BURST + 1) : 1;
  localparam int unsigned L1CntW = $clog2(L1_DEPTH) + 1;
  localparam int unsigned SnCntW = $clog2(SNOOP_DEPTH) + 1;

  dec_t              l1_dec, sn_dec;
  logic              l1_push, sn_push, l1_ill, sn_ill;
  logic              l1_full, l1_empty, sn_full, sn_empty;
  logic [L1CntW-1:0] l1_count;
  logic [SnCntW-1:0] sn_count;
  logic [EntryW-1:0] l1_head, sn_head;
  logic              load, burst_hit, sn_grant, l1_grant;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              req_valid_q, req_is_snoop_q;
  op_e               req_op_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              l1_overflow_q, snoop_overflow_q, illegal_op_q;
  logic [15:0]       illegal_count_q, illegal_count_d;
  logic [16:0]       ill_sum;
  logic              unused_counts;

  assign l1_dec  = decode_l1(l1_op);
  assign sn_dec  = decode_snoop(snoop_op);
  assign l1_push = l1_valid & l1_dec.legal;
  assign sn_push = snoop_valid & sn_dec.legal;
  assign l1_ill  = l1_valid & ~l1_dec.legal;
  assign sn_ill  = snoop_valid & ~sn_dec.legal;

  assign unused_counts = ^{l1_count, sn_count};

  l2_req_fifo #(
    .Width (EntryW),
    .Depth (L1_DEPTH)
  ) u_l1_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (l1_push),
    .data_i  ({l1_dec.op, l1_addr}),
    .pop_i   (l1_grant),
    .data_o  (l1_head),
    .full_o  (l1_full),
    .empty_o (l1_empty),
    .count_o (l1_count)
  );

  l2_req_fifo #(
    .Width (EntryW),
    .Depth (SNOOP_DEPTH)
  ) u_snoop_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (sn_push),
    .data_i  ({sn_dec.op, snoop_addr}),
    .pop_i   (sn_grant),
    .data_o  (sn_head),
    .full_o  (sn_full),
    .empty_o (sn_empty),
    .count_o (sn_count)
  );

  // Arbitration: snoop first unless the burst budget is spent while L1 waits.
  always_comb begin
    load      = ~req_valid_q | req_ready;
    burst_hit = (burst_q == BurstW'(MAX_SNOOP_BURST)) & ~l1_empty;
    sn_grant  = load & ~sn_empty & ~burst_hit;
    l1_grant  = load & ~l1_empty & ~sn_grant;
    burst_d   = burst_q;
    if (l1_empty || l1_grant) begin
      burst_d = '0;
    end else if (sn_grant) begin
      burst_d = burst_q + BurstW'(1);
    end
  end

  // Two illegal ops at one edge add 2; the sum is clamped at all-ones.
  always_comb begin
    ill_sum         = {1'b0, illegal_count_q} + 17'(l1_ill) + 17'(sn_ill);
    illegal_count_d = ill_sum[16] ? 16'hFFFF : ill_sum[15:0];
  end

  // Output register holds its payload until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_q    <= 1'b0;
      req_op_q       <= OP_DR;
      req_addr_q     <= '0;
      req_is_snoop_q <= 1'b0;
    end else if (load) begin
      req_valid_q <= sn_grant | l1_grant;
      if (sn_grant) begin
        req_op_q       <= op_e'(sn_head[EntryW-1 -: 3]);
        req_addr_q     <= sn_head[ADDR_W-1:0];
        req_is_snoop_q <= 1'b1;
      end else if (l1_grant) begin
        req_op_q       <= op_e'(l1_head[EntryW-1 -: 3]);
        req_addr_q     <= l1_head[ADDR_W-1:0];
        req_is_snoop_q <= 1'b0;
      end
    end
  end

  // Sticky overflow flags, illegal pulse/count and burst counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l1_overflow_q    <= 1'b0;
      snoop_overflow_q <= 1'b0;
      illegal_op_q     <= 1'b0;
      illegal_count_q  <= '0;
      burst_q          <= '0;
    end else begin
      if (l1_push && l1_full) l1_overflow_q    <= 1'b1;
      if (sn_push && sn_full) snoop_overflow_q <= 1'b1;
      illegal_op_q    <= l1_ill | sn_ill;
      illegal_count_q <= illegal_count_d;
      burst_q         <= burst_d;
    end
  end

  assign req_valid      = req_valid_q;
  assign req_op         = req_op_q;
  assign req_addr       = req_addr_q;
  assign req_is_snoop   = req_is_snoop_q;
  assign l1_overflow    = l1_overflow_q;
  assign snoop_overflow = snoop_overflow_q;
  assign illegal_op     = illegal_op_q;
  assign illegal_count  = illegal_count_q;

endmodule

// File: tb/tb_l2_bus_request_decoder.sv
// Bench for l2_bus_request_decoder: directed sequences, a decode vector table and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_l2_bus_request_decoder;

  localparam int unsigned AW   = 32;
  localparam int unsigned L1D  = 4;
  localparam int unsigned SD   = 4;
  localparam int unsigned MAXB = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          l1_valid = 1'b0, snoop_valid = 1'b0, req_ready = 1'b0;
  logic [15:0]   l1_op = '0;
  logic [7:0]    snoop_op = '0;
  logic [AW-1:0] l1_addr = '0, snoop_addr = '0;
  logic          req_valid, req_is_snoop, l1_overflow, snoop_overflow, illegal_op;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [15:0]   illegal_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l2_bus_request_decoder #(
    .ADDR_W          (AW),
    .L1_DEPTH        (L1D),
    .SNOOP_DEPTH     (SD),
    .MAX_SNOOP_BURST (MAXB)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .l1_valid       (l1_valid),
    .l1_op          (l1_op),
    .l1_addr        (l1_addr),
    .snoop_valid    (snoop_valid),
    .snoop_op       (snoop_op),
    .snoop_addr     (snoop_addr),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_is_snoop   (req_is_snoop),
    .l1_overflow    (l1_overflow),
    .snoop_overflow (snoop_overflow),
    .illegal_op     (illegal_op),
    .illegal_count  (illegal_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          op;
    logic [31:0] addr;
    bit          snoop;
  } ent_t;

  ent_t        l1q[$];
  ent_t        sq[$];
  bit          m_valid = 0, m_snoop = 0, m_l1ov = 0, m_snov = 0, m_ill = 0;
  int          m_op = 0, m_burst = 0, m_cnt = 0;
  logic [31:0] m_addr = '0;
  logic [15:0] l1_codes [3] = '{16'h4452, 16'h4457, 16'h4952};
  logic [7:0]  sn_codes [4] = '{8'h49, 8'h52, 8'h57, 8'h4D};

  function automatic int ref_l1(input logic [15:0] c);
    for (int i = 0; i < 3; i++) if (l1_codes[i] === c) return i;
    return -1;
  endfunction

  function automatic int ref_sn(input logic [7:0] c);
    for (int i = 0; i < 4; i++) if (sn_codes[i] === c) return 3 + i;
    return -1;
  endfunction

  task automatic model_clear();
    l1q.delete();
    sq.delete();
    m_valid = 0; m_snoop = 0; m_l1ov = 0; m_snov = 0; m_ill = 0;
    m_op = 0; m_burst = 0; m_cnt = 0; m_addr = '0;
  endtask

  task automatic model_step();
    int   l1n, sn, d;
    bit   sn_g, l1_g;
    ent_t e;
    l1n = l1q.size();
    sn  = sq.size();
    sn_g = 0;
    l1_g = 0;
    if (!m_valid || req_ready) begin
      if (sn > 0 && !(m_burst == MAXB && l1n > 0)) sn_g = 1;
      else if (l1n > 0) l1_g = 1;
      if (sn_g) e = sq.pop_front();
      else if (l1_g) e = l1q.pop_front();
      m_valid = sn_g || l1_g;
      if (m_valid) begin
        m_op = e.op; m_addr = e.addr; m_snoop = e.snoop;
      end
    end
    if (l1n == 0 || l1_g) m_burst = 0;
    else if (sn_g) m_burst++;
    m_ill = 0;
    if (l1_valid) begin
      d = ref_l1(l1_op);
      if (d < 0) begin m_ill = 1; m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1; end
      else if (l1n < L1D) l1q.push_back('{d, l1_addr, 1'b0});
      else m_l1ov = 1;
    end
    if (snoop_valid) begin
      d = ref_sn(snoop_op);
      if (d < 0) begin m_ill = 1; m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1; end
      else if (sn < SD) sq.push_back('{d, snoop_addr, 1'b1});
      else m_snov = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_clear();
    else model_step();
  end

  // Compare DUT to model on every falling edge while out of reset.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("model_req_valid", 32'(req_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model_req_op", 32'(req_op), 32'(m_op));
        chk("model_req_addr", req_addr, m_addr);
        chk("model_req_is_snoop", 32'(req_is_snoop), 32'(m_snoop));
      end
      chk("model_l1_overflow", 32'(l1_overflow), 32'(m_l1ov));
      chk("model_snoop_overflow", 32'(snoop_overflow), 32'(m_snov));
      chk("model_illegal_op", 32'(illegal_op), 32'(m_ill));
      chk("model_illegal_count", 32'(illegal_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    l1_valid = 0; snoop_valid = 0; l1_op = '0; snoop_op = '0;
  endtask

  typedef struct {
    bit          sn;
    logic [15:0] op;
    bit          legal;
    logic [2:0]  exp_op;
  } vec_t;

  vec_t        vt[12];
  bit          gs[$];
  logic [31:0] ga[$];
  logic [31:0] da[$];
  bit          exp_s [7] = '{1, 1, 1, 0, 1, 1, 1};
  logic [31:0] exp_a [7] = '{32'h100, 32'h101, 32'h102, 32'h900, 32'h103, 32'h104, 32'h105};
  int          r;

  initial begin
    vt[0]  = '{0, 16'h4452, 1, 3'd0};
    vt[1]  = '{0, 16'h4457, 1, 3'd1};
    vt[2]  = '{0, 16'h4952, 1, 3'd2};
    vt[3]  = '{1, 16'h0049, 1, 3'd3};
    vt[4]  = '{1, 16'h0052, 1, 3'd4};
    vt[5]  = '{1, 16'h0057, 1, 3'd5};
    vt[6]  = '{1, 16'h004D, 1, 3'd6};
    vt[7]  = '{0, 16'h5858, 0, 3'd0};
    vt[8]  = '{0, 16'h5244, 0, 3'd0};
    vt[9]  = '{0, 16'h4453, 0, 3'd0};
    vt[10] = '{1, 16'h0041, 0, 3'd0};
    vt[11] = '{1, 16'h0000, 0, 3'd0};

    idle();
    repeat (2) tick();
    reset_n = 1;
    tick();
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_l1_overflow", 32'(l1_overflow), 0);
    chk("rst_snoop_overflow", 32'(snoop_overflow), 0);
    chk("rst_illegal_count", 32'(illegal_count), 0);

    // DR with minimum latency
    req_ready = 1;
    l1_valid = 1; l1_op = 16'h4452; l1_addr = 32'h1000;
    tick(); idle();
    chk("s1_not_yet_valid", 32'(req_valid), 0);
    tick();
    chk("s1_valid", 32'(req_valid), 1);
    chk("s1_op", 32'(req_op), 0);
    chk("s1_addr", req_addr, 32'h1000);
    chk("s1_is_snoop", 32'(req_is_snoop), 0);
    chk("s1_flags", 32'({l1_overflow, snoop_overflow, illegal_op}), 0);
    tick();
    chk("s1_drained", 32'(req_valid), 0);

    // Simultaneous snoop M and L1 DW: snoop first
    l1_valid = 1; l1_op = 16'h4457; l1_addr = 32'h40;
    snoop_valid = 1; snoop_op = 8'h4D; snoop_addr = 32'hDEAD_BEE0;
    tick(); idle(); tick();
    chk("s2_first_op", 32'(req_op), 6);
    chk("s2_first_snoop", 32'(req_is_snoop), 1);
    chk("s2_first_addr", req_addr, 32'hDEAD_BEE0);
    tick();
    chk("s2_second_valid", 32'(req_valid), 1);
    chk("s2_second_op", 32'(req_op), 1);
    chk("s2_second_addr", req_addr, 32'h40);
    tick();

    // Back-pressure holds the payload
    req_ready = 0;
    snoop_valid = 1; snoop_op = 8'h52; snoop_addr = 32'h80;
    tick(); idle(); tick();
    chk("s3_loaded", 32'(req_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("s3_hold%0d_valid", i), 32'(req_valid), 1);
      chk($sformatf("s3_hold%0d_op", i), 32'(req_op), 4);
      chk($sformatf("s3_hold%0d_addr", i), req_addr, 32'h80);
    end
    req_ready = 1;
    tick();
    chk("s3_accepted", 32'(req_valid), 0);

    // Burst guard: S,S,S,L1,S,S,S
    for (int i = 0; i < 6; i++) begin
      snoop_valid = 1; snoop_op = 8'h49; snoop_addr = 32'h100 + 32'(i);
      if (i == 0) begin l1_valid = 1; l1_op = 16'h4952; l1_addr = 32'h900; end
      else l1_valid = 0;
      tick();
      if (req_valid) begin gs.push_back(req_is_snoop); ga.push_back(req_addr); end
    end
    idle();
    repeat (3) begin
      tick();
      if (req_valid) begin gs.push_back(req_is_snoop); ga.push_back(req_addr); end
    end
    chk("s4_grant_count", 32'(gs.size()), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < gs.size()) begin
        chk($sformatf("s4_grant%0d_src", i), 32'(gs[i]), 32'(exp_s[i]));
        chk($sformatf("s4_grant%0d_addr", i), ga[i], exp_a[i]);
      end
    end

    // L1 overflow with the output register occupied
    req_ready = 0;
    snoop_valid = 1; snoop_op = 8'h57; snoop_addr = 32'h500;
    tick(); idle(); tick();
    for (int i = 0; i < 5; i++) begin
      l1_valid = 1; l1_op = 16'h4452; l1_addr = 32'h2000 + 32'(i * 16);
      tick();
    end
    idle();
    chk("s5_l1_overflow", 32'(l1_overflow), 1);
    tick();
    chk("s5_l1_overflow_sticky", 32'(l1_overflow), 1);
    req_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_valid && !req_is_snoop) da.push_back(req_addr);
    end
    chk("s5_drain_count", 32'(da.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < da.size()) chk($sformatf("s5_drain%0d_addr", i), da[i], 32'h2000 + 32'(i * 16));
    end
    chk("s5_overflow_after_drain", 32'(l1_overflow), 1);
    chk("s5_snoop_overflow", 32'(snoop_overflow), 0);

    // Illegal opcodes after a fresh reset
    reset_n = 0; tick(); reset_n = 1; tick();
    chk("s6_reset_overflow", 32'(l1_overflow), 0);
    l1_valid = 1; l1_op = 16'h5858; l1_addr = 32'h3000;
    tick(); idle();
    chk("s6_illegal_pulse", 32'(illegal_op), 1);
    chk("s6_illegal_count", 32'(illegal_count), 1);
    tick();
    chk("s6_pulse_ends", 32'(illegal_op), 0);
    chk("s6_no_request", 32'(req_valid), 0);
    l1_valid = 1; l1_op = 16'h5858; snoop_valid = 1; snoop_op = 8'h58;
    tick(); idle();
    chk("s6_dual_pulse", 32'(illegal_op), 1);
    chk("s6_dual_count", 32'(illegal_count), 3);
    tick();
    chk("s6_dual_pulse_ends", 32'(illegal_op), 0);

    // Asynchronous reset mid-handshake
    req_ready = 0;
    snoop_valid = 1; snoop_op = 8'h52; snoop_addr = 32'h700;
    tick(); idle(); tick();
    chk("rh_pending", 32'(req_valid), 1);
    #2 reset_n = 0;
    #1;
    chk("rh_valid_drops", 32'(req_valid), 0);
    chk("rh_count_cleared", 32'(illegal_count), 0);
    tick();
    reset_n = 1;
    tick();
    chk("rh_no_replay", 32'(req_valid), 0);
    req_ready = 1;
    tick();
    chk("rh_no_replay_ready", 32'(req_valid), 0);

    // Decode table
    for (int i = 0; i < 12; i++) begin
      if (vt[i].sn) begin
        snoop_valid = 1; snoop_op = vt[i].op[7:0]; snoop_addr = 32'h4000 + 32'(i * 4);
      end else begin
        l1_valid = 1; l1_op = vt[i].op; l1_addr = 32'h4000 + 32'(i * 4);
      end
      tick(); idle();
      chk($sformatf("vec%0d_illegal", i), 32'(illegal_op), 32'(!vt[i].legal));
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(req_valid), 32'(vt[i].legal));
      if (vt[i].legal) begin
        chk($sformatf("vec%0d_op", i), 32'(req_op), 32'(vt[i].exp_op));
        chk($sformatf("vec%0d_is_snoop", i), 32'(req_is_snoop), 32'(vt[i].sn));
        chk($sformatf("vec%0d_addr", i), req_addr, 32'h4000 + 32'(i * 4));
      end
      tick();
    end

    // Illegal count saturation
    l1_valid = 1; l1_op = 16'h5858; snoop_valid = 1; snoop_op = 8'h58;
    repeat (32800) tick();
    chk("sat_count", 32'(illegal_count), 32'hFFFF);
    tick();
    chk("sat_count_holds", 32'(illegal_count), 32'hFFFF);
    chk("sat_pulse", 32'(illegal_op), 1);
    idle();
    tick();

    // Randomized traffic; the model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      l1_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      l1_op = (r < 3) ? l1_codes[r] : (r == 9) ? 16'($urandom) : l1_codes[r % 3];
      l1_addr = $urandom;
      snoop_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      snoop_op = (r < 4) ? sn_codes[r] : (r == 9) ? 8'($urandom) : sn_codes[r % 4];
      snoop_addr = $urandom;
      if (i < 2000) req_ready = ($urandom_range(0, 3) != 0);
      else req_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    req_ready = 1;
    repeat (12) tick();
    chk("rand_final_drained", 32'(req_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
